pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, flush, and an optional skid buffer. It replaces the fixed-field IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. Each stage now carries one packed payload of `WIDTH` bits with real backpressure, so multi-cycle units such as cache misses and the divider can stall the pipe. Flush kills the stage contents for exceptions, `ERET` and branch redirects.

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised pipeline stage register with valid/ready handshake,
//            synchronous flush and an optional second (skid) entry.
//            Build option: define PIPE_SKID_EN to add the skid entry. This
//            registers in_ready and lets level reach 2.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    // Main entry: always holds the oldest payload and drives the outputs.
    logic             r_main_v;
    logic [WIDTH-1:0] r_main_d;

    // True when the main entry may be overwritten this cycle.
    logic w_main_free;
    // Upstream handshake completes this cycle.
    logic w_in_xfer;

    assign w_main_free = !r_main_v || out_ready;
    assign w_in_xfer   = in_valid && in_ready;

    assign out_valid = r_main_v;
    assign out_data  = r_main_d;

`ifdef PIPE_SKID_EN
    // Skid entry: holds the younger payload accepted while main was stalled.
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid_d;

    // in_ready depends only on a flop, so it has no path from out_ready.
    assign in_ready = !r_skid_v;
    assign level    = {1'b0, r_main_v} + {1'b0, r_skid_v};

    // Main entry: refill from skid first to keep order, otherwise from input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                r_main_v <= 1'b1;
                r_main_d <= r_skid_d;
            end else if (w_in_xfer) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
            end else begin
                r_main_v <= 1'b0;
            end
        end
    end

    // Skid entry: fills when input arrives against a stalled main entry and
    // empties when its payload moves into main. No input can arrive while
    // it is full, because in_ready is low then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_v <= 1'b0;
            r_skid_d <= RESET_VAL;
        end else if (flush) begin
            r_skid_v <= 1'b0;
        end else if (w_main_free) begin
            r_skid_v <= 1'b0;
        end else if (w_in_xfer) begin
            r_skid_v <= 1'b1;
            r_skid_d <= in_data;
        end
    end
`else
    // Single entry: ready whenever main is empty or being consumed.
    assign in_ready = w_main_free;
    assign level    = {1'b0, r_main_v};

    // Main entry: load on input transfer, otherwise go empty and keep data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (w_main_free) begin
            if (w_in_xfer) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
            end else begin
                r_main_v <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Scoreboard bench for pipe_stage_reg (WIDTH = 8). The reference
//            model is a FIFO queue of accepted payloads. Build with or without
//            PIPE_SKID_EN to match the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int         c_width = 8;
    localparam logic [7:0] c_rval  = 8'h3C;
`ifdef PIPE_SKID_EN
    localparam int         c_cap   = 2;
`else
    localparam int         c_cap   = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;

    // Reference model: payloads accepted and not yet delivered, oldest first.
    logic [7:0] q[$];
    logic [7:0] last_shown = c_rval;

    pipe_stage_reg #(.WIDTH(c_width), .RESET_VAL(c_rval)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Input side of the scoreboard: record every accepted, non-flushed payload.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst && in_valid && in_ready && !flush)
                q.push_back(in_data);
        end
    end

    // Output side: compare DUT state with the model, then retire entries.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
                chk("level", {30'd0, level}, q.size());
                chk("in_ready", {31'd0, in_ready},
                    {31'd0, (q.size() < c_cap) || (c_cap == 1 && out_ready)});
                if (q.size() > 0) last_shown = q[0];
                chk("out_data", {24'd0, out_data}, {24'd0, last_shown});
                if (flush) begin
                    q.delete();
                    last_shown = c_rval;
                end else if (q.size() > 0 && out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic ir_before;

        // Reset held with input offered: outputs stay at reset values.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, {24'd0, c_rval});
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_level", {30'd0, level}, 32'd0);

        // First transfer after release, held at the output.
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        cyc(0, 8'h00, 0, 0);
        #1;
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data", {24'd0, out_data}, 32'hA5);
        cyc(0, 8'h00, 1, 0);

        // Back-to-back streaming.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 1, 0);
        repeat (3) cyc(0, 8'h00, 1, 0);

        // Stall builds up the stage, then drains in order.
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h03, 0, 0);
`ifdef PIPE_SKID_EN
        // in_ready must not follow out_ready within a cycle.
        #3;
        ir_before = in_ready;
        out_ready = 1'b1;
        #1;
        chk("in_ready_comb", {31'd0, in_ready}, {31'd0, ir_before});
        out_ready = 1'b0;
`else
        ir_before = 1'b0;
`endif
        cyc(1, 8'h03, 0, 0);
        repeat (3) cyc(1, 8'h03, 1, 0);
        repeat (4) cyc(0, 8'h00, 1, 0);

        // Flush with full stage and a same-cycle input offer.
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h7F, 0, 1);
        cyc(0, 8'h00, 0, 0);
        #1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_level", {30'd0, level}, 32'd0);
        chk("flush_data", {24'd0, out_data}, {24'd0, c_rval});
        repeat (2) cyc(0, 8'h00, 1, 0);

        // Asynchronous reset between edges while stalled.
        cyc(1, 8'h44, 0, 0);
        cyc(1, 8'h55, 0, 0);
        cyc(0, 8'h00, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, {24'd0, c_rval});
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_level", {30'd0, level}, 32'd0);
        q.delete();
        last_shown = c_rval;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random handshake with occasional flush.
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) == 0);
        repeat (4) cyc(0, 8'h00, 1, 0);
        @(posedge clk);
        #4;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
